// File: rtl/nbits_pkg.sv
// Shared types and helpers for the bit-serial adder slice.
package nbits_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} serial_state_t;

  // Counter must hold values 0..n, hence n+1 distinct codes.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder used as the arithmetic slice of the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/nbits_serial_adder.sv
// Bit-serial n-bit adder: one full-adder step per clock, LSB first,
// wrapped in a start/busy/done handshake with registered s/cout.
module nbits_serial_adder
  import nbits_pkg::*;
#(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] s,
  output logic         cout
);

  localparam int cw = cnt_width(n);

  serial_state_t state, state_next;
  logic [n-1:0]  a_sh, b_sh, r_sh, r_next;
  logic [cw-1:0] cnt;
  logic          carry, fa_s, fa_c, last_bit;

  full_adder u_fa (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .cin (carry),
    .s   (fa_s),
    .cout(fa_c)
  );

  // Sum bits enter at the MSB so the first (LSB) bit lands in bit 0 after n shifts.
  always_comb begin
    r_next        = r_sh >> 1;
    r_next[n-1]   = fa_s;
  end

  assign last_bit = (cnt == cw'(n - 1));

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= 1'b0;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          r_sh  <= r_next;
          carry <= fa_c;
          cnt   <= cnt + cw'(1);
          // Publish the result on the same edge that enters DONE.
          if (last_bit) begin
            s    <= r_next;
            cout <= fa_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nbits_serial_adder.sv
// Scoreboard bench for nbits_serial_adder at n = 4, 1 and 8.
module tb_nbits_serial_adder;

  typedef struct {
    logic [7:0] s;
    logic       c;
    int         acc;
  } exp_t;

  localparam int NW[3] = '{4, 1, 8};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_q = 1'b1;
  logic [2:0]      start = '0;
  logic [2:0][7:0] a_in  = '0;
  logic [2:0][7:0] b_in  = '0;
  logic [2:0]      busy_o, done_o, cout_o;
  logic [2:0][7:0] s_o;
  logic [3:0]      s4;
  logic            s1;
  logic [7:0]      s8;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[3][$];
  logic [7:0] last_s[3];
  logic       last_c[3];
  int         busy_cnt[3];

  always #5 clk = ~clk;

  nbits_serial_adder #(.n(4)) u4 (
    .clk(clk), .rst(rst), .start(start[0]), .a(a_in[0][3:0]), .b(b_in[0][3:0]),
    .busy(busy_o[0]), .done(done_o[0]), .s(s4), .cout(cout_o[0])
  );
  nbits_serial_adder #(.n(1)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .a(a_in[1][0]), .b(b_in[1][0]),
    .busy(busy_o[1]), .done(done_o[1]), .s(s1), .cout(cout_o[1])
  );
  nbits_serial_adder #(.n(8)) u8 (
    .clk(clk), .rst(rst), .start(start[2]), .a(a_in[2]), .b(b_in[2]),
    .busy(busy_o[2]), .done(done_o[2]), .s(s8), .cout(cout_o[2])
  );

  assign s_o[0] = {4'b0, s4};
  assign s_o[1] = {7'b0, s1};
  assign s_o[2] = s8;

  always @(posedge clk) begin
    cyc++;
    rst_q <= rst;
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected results on done, otherwise checks the outputs hold.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (rst_q) begin
        last_s[i]   = '0;
        last_c[i]   = 1'b0;
        busy_cnt[i] = 0;
      end
      if (busy_o[i]) busy_cnt[i]++;
      if (done_o[i]) begin
        if (sb[i].size() == 0) begin
          checkOutput($sformatf("spurious done u%0d", i), 1, 0);
        end else begin
          e = sb[i].pop_front();
          checkOutput($sformatf("sum u%0d", i), int'(s_o[i]), int'(e.s));
          checkOutput($sformatf("cout u%0d", i), int'(cout_o[i]), int'(e.c));
          checkOutput($sformatf("latency u%0d", i), cyc - e.acc, NW[i]);
          checkOutput($sformatf("busy cycles u%0d", i), busy_cnt[i], NW[i]);
          last_s[i] = e.s;
          last_c[i] = e.c;
        end
        busy_cnt[i] = 0;
      end else begin
        checkOutput($sformatf("hold s u%0d", i), int'(s_o[i]), int'(last_s[i]));
        checkOutput($sformatf("hold cout u%0d", i), int'(cout_o[i]), int'(last_c[i]));
      end
    end
  end

  // Called at a negedge: waits for IDLE, pulses start for one cycle, records expectation.
  task automatic applyStimulus(input int i, input int x, input int y);
    int w;
    int mask;
    int xm, ym, sum;
    exp_t e;
    w = 0;
    while ((busy_o[i] || done_o[i]) && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) begin
      checkOutput($sformatf("idle timeout u%0d", i), 0, 1);
      return;
    end
    mask     = (1 << NW[i]) - 1;
    xm       = x & mask;
    ym       = y & mask;
    sum      = xm + ym;
    a_in[i]  = 8'(xm);
    b_in[i]  = 8'(ym);
    start[i] = 1'b1;
    e.s      = 8'(sum & mask);
    e.c      = (sum >> NW[i]) != 0;
    e.acc    = cyc + 1;
    sb[i].push_back(e);
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic waitIdle(input int i);
    int w;
    w = 0;
    while ((sb[i].size() != 0 || busy_o[i] || done_o[i]) && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) checkOutput($sformatf("drain timeout u%0d", i), sb[i].size(), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset busy", int'(busy_o[0]), 0);
    checkOutput("reset done", int'(done_o[0]), 0);
    checkOutput("reset s", int'(s_o[0]), 0);

    applyStimulus(0, 2, 3);
    applyStimulus(0, 5, 2);
    applyStimulus(0, 5, 5);
    applyStimulus(0, 15, 1);
    applyStimulus(0, 15, 15);
    waitIdle(0);

    // A second start during RUN must be ignored.
    applyStimulus(0, 2, 3);
    a_in[0]  = 8'd1;
    b_in[0]  = 8'd1;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    waitIdle(0);

    // Reset on the second RUN cycle abandons the addition.
    applyStimulus(0, 7, 1);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) sb[i].delete();
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid-run reset s", int'(s_o[0]), 0);
    checkOutput("mid-run reset cout", int'(cout_o[0]), 0);
    checkOutput("mid-run reset busy", int'(busy_o[0]), 0);
    checkOutput("mid-run reset done", int'(done_o[0]), 0);
    applyStimulus(0, 3, 4);
    waitIdle(0);

    for (int k = 0; k < 20; k++) applyStimulus(0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    waitIdle(0);

    applyStimulus(1, 1, 1);
    for (int k = 0; k < 4; k++) applyStimulus(1, k & 1, k >> 1);
    for (int k = 0; k < 6; k++) applyStimulus(1, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
    waitIdle(1);

    applyStimulus(2, 200, 100);
    applyStimulus(2, 255, 255);
    applyStimulus(2, 0, 0);
    for (int k = 0; k < 12; k++) applyStimulus(2, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    waitIdle(2);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nbits_serial_adder.md
Name: nbits_serial_adder

Overview:
- Bit-serial n-bit adder; computes s = a + b, with cout as the carry out of the MSB.
- Inverse of the n-bit subtractor: feeding it the subtractor's difference and subtrahend recovers the minuend.
- Processes one bit per clock, LSB first, behind a start/busy/done handshake.
- Lab-level datapath block, reused as the reference checker for subtractor results in self-checking benches.

Parameters:
- n, 4, operand and result width in bits (n >= 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  n  first operand; captured on accepted start.
- b  input  n  second operand; captured on accepted start.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse when s/cout are valid.
- s  output  n  sum, low n bits.
- cout  output  1  carry out of bit n-1.

Behaviour:
- Reset (rst sampled high at a rising edge):
  - state = IDLE; s = 0; cout = 0; busy = 0; done = 0.
  - Internal shift registers, carry flop and bit counter are cleared.
  - Reset overrides all other inputs.
  - Reset mid-operation abandons the addition; no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy = 0.
  - On start = 1: latch a and b into shift registers, clear the carry flop, set counter = 0, go to RUN.
  - s and cout keep their last result; they are not cleared by start.
- RUN:
  - busy = 1.
  - Each cycle, full_adder sums operand bit [0] of each shift register with the carry flop.
  - The sum bit shifts into the result register at the MSB end, so after n cycles bit 0 is in the LSB position.
  - The carry flop updates with the full_adder carry; both operand registers shift right by 1; counter increments.
  - When counter == n-1 in this cycle: next state = DONE.
- DONE (one cycle):
  - busy = 0; done = 1.
  - s = assembled result register; cout = final carry.
  - Next state = IDLE unconditionally; start is ignored in DONE.
- Outputs s and cout are registered. They change only on entry to DONE or on reset, and hold between operations.
- start while busy = 1 or in DONE is ignored; a, b changes after acceptance have no effect.
- Latency: start accepted at edge k; RUN occupies edges k+1..k+n; done = 1 in the cycle after edge k+n. Total n+1 cycles from the accepting edge to done.
- Minimum start-to-start spacing is n+2 cycles. Holding start continuously re-triggers at each return to IDLE.
- Arithmetic is unsigned, modulo 2^n for s; cout = 1 iff a + b >= 2^n.
- Counter width is $clog2(n+1); for n = 1, RUN lasts exactly one cycle.

Decomposition:
- Shared package nbits_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} serial_state_t.
  - Helper function cnt_width(n) = $clog2(n+1).
- One sub-module, full_adder: combinational, inputs a, b, cin; outputs s, cout. Instantiated once in the bit slice.
- FSM, shift registers and counter live in nbits_serial_adder.

Test Plan:
- n=4, a=0010 (2), b=0011 (3), start 1 cycle -> busy high 4 cycles, done pulse at cycle 5 after acceptance, s=0101 (5), cout=0.
- n=4, sequences 5+2 and 5+5 -> s=0111 (7) cout=0, then s=1010 (10) cout=0. Each result matches the minuend of the subtractor cases 7-2 and 10-5.
- n=4, a=1111, b=0001 -> s=0000, cout=1. Then a=1111, b=1111 -> s=1110, cout=1.
- start re-pulsed with a=0001, b=0001 during RUN of 0010+0011 -> ignored; result s=0101; exactly one done pulse.
- rst asserted on the 2nd RUN cycle of 0111+0001 -> next cycle s=0, cout=0, busy=0, done=0, state IDLE, no done pulse. A subsequent 0011+0100 yields s=0111.
- Parameter sweep: n=1 (1+1 -> s=0, cout=1, done 2 cycles after accept) and n=8 (200+100 -> s=44, cout=1, done 9 cycles after accept).
